forward_operand_datapath: RTL and testbench

FORWARD_OPERAND_DATAPATH -- requirements
Module: forward_operand_datapath

---
 rtl/forward_operand_datapath.sv | 143 ++++++++++++++
 tb/tb_forward_operand_datapath.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/forward_operand_datapath.sv
// ---------------------------------------------------------------------------
// forward_operand_datapath
//
// Operand-forwarding datapath between the register-read (RR) stage and the
// EX stage of a short in-order pipeline. Each EX operand is taken from the
// youngest producer whose forward select is low (EX > MA > WB), falling back
// to the register file. The block also carries the ALU result down through
// the MA and WB stages so that it can be forwarded from them.
//
// Ports
//   clk                       pipeline clock
//   rst_n                     asynchronous active-low reset
//   ex_sel1/ma_sel1/wb_sel1   operand-A forward selects, active-low
//   ex_sel2/ma_sel2/wb_sel2   operand-B forward selects, active-low
//   clk_ctrl                  1 = RR stage advances, 0 = load-use stall
//   rr_valid                  RR-stage instruction is real
//   rf_a, rf_b     [15:0]     register-file read data
//   alu_res        [15:0]     combinational ALU result of the EX stage
//   ma_load                   MA-stage instruction is a load
//   mem_rdata      [15:0]     data-memory read data of the MA stage
//   op_a, op_b     [15:0]     registered EX operands
//   ex_valid/ma_valid/wb_valid stage-occupancy flags
//   wb_data        [15:0]     write-back value
//   stall_cnt      [7:0]      saturating stall-cycle count
//   fwd_cnt        [7:0]      saturating count of cycles with a forward taken
//
// All outputs are driven straight from registers.
// ---------------------------------------------------------------------------
module forward_operand_datapath (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_sel1,
    input  logic        ma_sel1,
    input  logic        wb_sel1,
    input  logic        ex_sel2,
    input  logic        ma_sel2,
    input  logic        wb_sel2,
    input  logic        clk_ctrl,
    input  logic        rr_valid,
    input  logic [15:0] rf_a,
    input  logic [15:0] rf_b,
    input  logic [15:0] alu_res,
    input  logic        ma_load,
    input  logic [15:0] mem_rdata,
    output logic [15:0] op_a,
    output logic [15:0] op_b,
    output logic        ex_valid,
    output logic        ma_valid,
    output logic        wb_valid,
    output logic [15:0] wb_data,
    output logic [7:0]  stall_cnt,
    output logic [7:0]  fwd_cnt
);

    logic [15:0] op_a_q, op_a_d;
    logic [15:0] op_b_q, op_b_d;
    logic [15:0] ma_res_q;
    logic [15:0] wb_res_q;
    logic        ex_valid_q, ex_valid_d;
    logic        ma_valid_q;
    logic        wb_valid_q;
    logic [7:0]  stall_cnt_q, stall_cnt_d;
    logic [7:0]  fwd_cnt_q, fwd_cnt_d;

    logic [15:0] ma_src;
    logic [15:0] fwd_a;
    logic [15:0] fwd_b;
    logic        any_sel;

    // A load in MA forwards the memory data, otherwise the carried ALU result.
    assign ma_src = ma_load ? mem_rdata : ma_res_q;

    // Priority muxes: the youngest producer wins when several selects are low.
    always_comb begin
        fwd_a = rf_a;
        if (!ex_sel1)      fwd_a = alu_res;
        else if (!ma_sel1) fwd_a = ma_src;
        else if (!wb_sel1) fwd_a = wb_res_q;

        fwd_b = rf_b;
        if (!ex_sel2)      fwd_b = alu_res;
        else if (!ma_sel2) fwd_b = ma_src;
        else if (!wb_sel2) fwd_b = wb_res_q;
    end

    assign any_sel = !(ex_sel1 && ma_sel1 && wb_sel1 && ex_sel2 && ma_sel2 && wb_sel2);

    always_comb begin
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        ex_valid_d  = 1'b0;
        stall_cnt_d = stall_cnt_q;
        fwd_cnt_d   = fwd_cnt_q;
        if (clk_ctrl) begin
            op_a_d     = fwd_a;
            op_b_d     = fwd_b;
            ex_valid_d = rr_valid;
            if (rr_valid && any_sel && (fwd_cnt_q != 8'hFF)) begin
                fwd_cnt_d = fwd_cnt_q + 8'd1;
            end
        end else begin
            // Stall: operands hold and a bubble is pushed into EX.
            if (stall_cnt_q != 8'hFF) begin
                stall_cnt_d = stall_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a_q      <= 16'h0000;
            op_b_q      <= 16'h0000;
            ma_res_q    <= 16'h0000;
            wb_res_q    <= 16'h0000;
            ex_valid_q  <= 1'b0;
            ma_valid_q  <= 1'b0;
            wb_valid_q  <= 1'b0;
            stall_cnt_q <= 8'h00;
            fwd_cnt_q   <= 8'h00;
        end else begin
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            ex_valid_q  <= ex_valid_d;
            stall_cnt_q <= stall_cnt_d;
            fwd_cnt_q   <= fwd_cnt_d;
            // Downstream stages advance every cycle regardless of a stall.
            ma_res_q    <= alu_res;
            ma_valid_q  <= ex_valid_q;
            wb_res_q    <= ma_src;
            wb_valid_q  <= ma_valid_q;
        end
    end

    assign op_a      = op_a_q;
    assign op_b      = op_b_q;
    assign ex_valid  = ex_valid_q;
    assign ma_valid  = ma_valid_q;
    assign wb_valid  = wb_valid_q;
    assign wb_data   = wb_res_q;
    assign stall_cnt = stall_cnt_q;
    assign fwd_cnt   = fwd_cnt_q;

endmodule

// File: tb/tb_forward_operand_datapath.sv
// Bench for forward_operand_datapath: directed steps followed by randomized
// traffic, every cycle compared against a behavioural pipeline model.
module tb_forward_operand_datapath;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        ex_sel1, ma_sel1, wb_sel1;
  logic        ex_sel2, ma_sel2, wb_sel2;
  logic        clk_ctrl, rr_valid, ma_load;
  logic [15:0] rf_a, rf_b, alu_res, mem_rdata;
  logic [15:0] op_a, op_b, wb_data;
  logic        ex_valid, ma_valid, wb_valid;
  logic [7:0]  stall_cnt, fwd_cnt;

  forward_operand_datapath dut (
    .clk(clk), .rst_n(rst_n),
    .ex_sel1(ex_sel1), .ma_sel1(ma_sel1), .wb_sel1(wb_sel1),
    .ex_sel2(ex_sel2), .ma_sel2(ma_sel2), .wb_sel2(wb_sel2),
    .clk_ctrl(clk_ctrl), .rr_valid(rr_valid),
    .rf_a(rf_a), .rf_b(rf_b), .alu_res(alu_res),
    .ma_load(ma_load), .mem_rdata(mem_rdata),
    .op_a(op_a), .op_b(op_b),
    .ex_valid(ex_valid), .ma_valid(ma_valid), .wb_valid(wb_valid),
    .wb_data(wb_data), .stall_cnt(stall_cnt), .fwd_cnt(fwd_cnt)
  );

  int compared = 0;
  int mismatched = 0;

  // ---------------- reference model ----------------
  // Pipeline contents as plain values; pipe[0]=EX, [1]=MA, [2]=WB results.
  logic [15:0] m_op_a, m_op_b, m_ma_res, m_wb_res;
  logic        m_ex_v, m_ma_v, m_wb_v;
  int          m_stalls, m_fwds;

  task automatic model_reset();
    m_op_a = '0; m_op_b = '0; m_ma_res = '0; m_wb_res = '0;
    m_ex_v = 0; m_ma_v = 0; m_wb_v = 0;
    m_stalls = 0; m_fwds = 0;
  endtask

  // First low select in priority order wins; sources listed youngest first.
  function automatic logic [15:0] choose(logic [2:0] sel_n, logic [15:0] src[3], logic [15:0] rf);
    for (int i = 0; i < 3; i++) if (!sel_n[i]) return src[i];
    return rf;
  endfunction

  task automatic model_edge();
    logic [15:0] src[3];
    logic [15:0] ma_out;
    ma_out = ma_load ? mem_rdata : m_ma_res;
    src[0] = alu_res; src[1] = ma_out; src[2] = m_wb_res;
    if (clk_ctrl) begin
      if (rr_valid && ({ex_sel1, ma_sel1, wb_sel1, ex_sel2, ma_sel2, wb_sel2} != 6'b111111))
        m_fwds = (m_fwds + 1 > 255) ? 255 : m_fwds + 1;
      m_op_a = choose({wb_sel1, ma_sel1, ex_sel1}, src, rf_a);
      m_op_b = choose({wb_sel2, ma_sel2, ex_sel2}, src, rf_b);
    end else begin
      m_stalls = (m_stalls + 1 > 255) ? 255 : m_stalls + 1;
    end
    m_wb_v = m_ma_v;
    m_ma_v = m_ex_v;
    m_ex_v = clk_ctrl ? rr_valid : 1'b0;
    m_wb_res = ma_out;
    m_ma_res = alu_res;
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string where);
    chk({where, ".op_a"}, op_a, m_op_a);
    chk({where, ".op_b"}, op_b, m_op_b);
    chk({where, ".ex_valid"}, {15'd0, ex_valid}, {15'd0, m_ex_v});
    chk({where, ".ma_valid"}, {15'd0, ma_valid}, {15'd0, m_ma_v});
    chk({where, ".wb_valid"}, {15'd0, wb_valid}, {15'd0, m_wb_v});
    chk({where, ".wb_data"}, wb_data, m_wb_res);
    chk({where, ".stall_cnt"}, {8'd0, stall_cnt}, 16'(m_stalls));
    chk({where, ".fwd_cnt"}, {8'd0, fwd_cnt}, 16'(m_fwds));
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    {ex_sel1, ma_sel1, wb_sel1, ex_sel2, ma_sel2, wb_sel2} = 6'b111111;
    clk_ctrl = 1; rr_valid = 1; ma_load = 0;
    rf_a = '0; rf_b = '0; alu_res = '0; mem_rdata = '0;
  endtask

  task automatic random_inputs();
    ex_sel1 = ($urandom_range(2) != 0); ma_sel1 = ($urandom_range(2) != 0);
    wb_sel1 = ($urandom_range(2) != 0); ex_sel2 = ($urandom_range(2) != 0);
    ma_sel2 = ($urandom_range(2) != 0); wb_sel2 = ($urandom_range(2) != 0);
    clk_ctrl = ($urandom_range(3) != 0);
    rr_valid = ($urandom_range(4) != 0);
    ma_load  = $urandom_range(1);
    rf_a = 16'($urandom); rf_b = 16'($urandom);
    alu_res = 16'($urandom); mem_rdata = 16'($urandom);
  endtask

  // One clock edge: model advances with the inputs present at the edge,
  // outputs are sampled 1 time unit later.
  task automatic step(input string where);
    model_edge();
    @(posedge clk);
    #1;
    check_all(where);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    idle_inputs();
    model_reset();
    #12;
    check_all("reset");

    @(negedge clk); rst_n = 1;

    // Plain register-file read, no forwarding.
    rf_a = 16'h0011; rf_b = 16'h0022;
    step("rf_only");
    chk("rf_only.op_a_const", op_a, 16'h0011);
    chk("rf_only.op_b_const", op_b, 16'h0022);
    chk("rf_only.fwd_cnt_const", {8'd0, fwd_cnt}, 16'd0);

    // Prime MA with 5555, then EX and MA both selected for A: EX wins.
    alu_res = 16'h5555;
    step("prime_ma");
    alu_res = 16'hAAAA; ex_sel1 = 0; ma_sel1 = 0;
    step("ex_over_ma");
    chk("ex_over_ma.op_a_const", op_a, 16'hAAAA);
    chk("ex_over_ma.fwd_cnt_const", {8'd0, fwd_cnt}, 16'd1);

    // Load in MA forwards memory data into B and on to write-back.
    idle_inputs(); alu_res = 16'h1234;
    step("prime_load");
    alu_res = 16'h0000; ma_sel2 = 0; ma_load = 1; mem_rdata = 16'hBEEF;
    step("load_fwd");
    chk("load_fwd.op_b_const", op_b, 16'hBEEF);
    chk("load_fwd.wb_data_const", wb_data, 16'hBEEF);
    ma_sel2 = 1;
    step("load_wb");
    chk("load_wb.wb_data_const", wb_data, 16'hBEEF);

    // Single stall: op_a holds 0007, bubble in EX, next cycle bubble in MA.
    idle_inputs(); rf_a = 16'h0007;
    step("pre_stall");
    rf_a = 16'h9999; clk_ctrl = 0;
    step("stall");
    chk("stall.op_a_const", op_a, 16'h0007);
    chk("stall.ex_valid_const", {15'd0, ex_valid}, 16'd0);
    chk("stall.stall_cnt_const", {8'd0, stall_cnt}, 16'd1);
    clk_ctrl = 1;
    step("post_stall");
    chk("post_stall.ma_valid_const", {15'd0, ma_valid}, 16'd0);

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      random_inputs();
      step("random");
    end

    // Saturate fwd_cnt with forwarding cycles.
    idle_inputs(); wb_sel2 = 0;
    for (int i = 0; i < 260; i++) begin
      rf_a = 16'($urandom);
      step("fwd_sat");
    end
    chk("fwd_sat.fwd_cnt_const", {8'd0, fwd_cnt}, 16'h00FF);

    // Saturate stall_cnt with 256+ consecutive stalls.
    idle_inputs(); clk_ctrl = 0;
    for (int i = 0; i < 262; i++) begin
      alu_res = 16'($urandom);
      step("stall_sat");
    end
    chk("stall_sat.stall_cnt_const", {8'd0, stall_cnt}, 16'h00FF);

    // Asynchronous reset in the middle of the stall sequence.
    #2;
    rst_n = 0;
    model_reset();
    #1;
    check_all("async_reset");
    chk("async_reset.stall_cnt_const", {8'd0, stall_cnt}, 16'd0);
    @(posedge clk); #1;
    check_all("held_reset");

    // Release: block behaves as if no stall was pending.
    @(negedge clk); rst_n = 1;
    idle_inputs(); rf_a = 16'h0A0A; rf_b = 16'h0B0B;
    step("after_reset");
    chk("after_reset.ex_valid_const", {15'd0, ex_valid}, 16'd1);
    for (int i = 0; i < 100; i++) begin
      random_inputs();
      step("random2");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
